// File: rtl/nvdla_csb_pkg.sv
// Shared CSB definitions: payload field positions, arbiter FSM encoding and
// the synthesised error-response builder.
package nvdla_csb_pkg;

  localparam int CSB_REQ_PD_W  = 63;
  localparam int CSB_RESP_PD_W = 34;

  // Request payload fields
  localparam int CSB_REQ_ADDR_LSB    = 0;
  localparam int CSB_REQ_ADDR_MSB    = 21;
  localparam int CSB_REQ_WDAT_LSB    = 22;
  localparam int CSB_REQ_WDAT_MSB    = 53;
  localparam int CSB_REQ_WRITE_BIT   = 54;
  localparam int CSB_REQ_NPOSTED_BIT = 55;
  localparam int CSB_REQ_SRCPRIV_BIT = 56;
  localparam int CSB_REQ_WRBE_LSB    = 57;
  localparam int CSB_REQ_WRBE_MSB    = 60;
  localparam int CSB_REQ_LEVEL_LSB   = 61;
  localparam int CSB_REQ_LEVEL_MSB   = 62;

  // Response payload fields
  localparam int CSB_RESP_RDAT_LSB     = 0;
  localparam int CSB_RESP_RDAT_MSB     = 31;
  localparam int CSB_RESP_ERROR_BIT    = 32;
  localparam int CSB_RESP_IS_WRITE_BIT = 33;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2
  } csb_arb_state_e;

  // Response returned to a master when the cfgrom never answered.
  function automatic logic [CSB_RESP_PD_W-1:0] csb_err_resp(input logic is_write);
    logic [CSB_RESP_PD_W-1:0] pd;
    pd = '0;
    pd[CSB_RESP_ERROR_BIT]    = 1'b1;
    pd[CSB_RESP_IS_WRITE_BIT] = is_write;
    return pd;
  endfunction

endpackage

// File: rtl/nvdla_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ. Returns one-hot grant, its index and a valid flag.
module nvdla_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;
  logic [IDX_W-1:0] pick_s;
  logic             hit_s;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    sum_s  = '0;
    cand_s = '0;
    pick_s = '0;
    hit_s  = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum_s = {1'b0, ptr_i} + (IDX_W+1)'(off);
      if (sum_s >= NUM_REQ_W) begin
        cand_s = IDX_W'(sum_s - NUM_REQ_W);
      end else begin
        cand_s = sum_s[IDX_W-1:0];
      end
      if (req_i[cand_s]) begin
        pick_s = cand_s;
        hit_s  = 1'b1;
      end else begin
        pick_s = pick_s;
        hit_s  = hit_s;
      end
    end
  end

  // Expand the chosen index into the one-hot grant.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = pick_s;
    gnt_vld_o = hit_s;
    if (hit_s) begin
      gnt_o[pick_s] = 1'b1;
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/nvdla_cfgrom_csb_arb.sv
// Shares the single cfgrom CSB target among NUM_REQ masters. One transaction
// is outstanding at a time; its response (or a synthesised timeout error) is
// routed back to the master that issued it.
module nvdla_cfgrom_csb_arb
  import nvdla_csb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                              nvdla_core_clk,
  input  logic                              nvdla_core_rst,
  input  logic [CSB_REQ_PD_W*NUM_REQ-1:0]   req_pd,
  input  logic [NUM_REQ-1:0]                req_pvld,
  output logic [NUM_REQ-1:0]                req_prdy,
  output logic [CSB_RESP_PD_W*NUM_REQ-1:0]  resp_pd,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [CSB_REQ_PD_W-1:0]           csb2cfgrom_req_pd,
  output logic                              csb2cfgrom_req_pvld,
  input  logic                              csb2cfgrom_req_prdy,
  input  logic [CSB_RESP_PD_W-1:0]          cfgrom2csb_resp_pd,
  input  logic                              cfgrom2csb_resp_valid,
  output logic                              resp_drop
);

  localparam int              IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int              CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  csb_arb_state_e                   state_q;
  logic [IDX_W-1:0]                 rr_ptr_q;
  logic [NUM_REQ-1:0]               gnt_oh_q;
  logic [CSB_REQ_PD_W-1:0]          pd_q;
  logic                             pvld_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [NUM_REQ-1:0]               resp_valid_q;
  logic [CSB_RESP_PD_W*NUM_REQ-1:0] resp_pd_q;
  logic                             resp_drop_q;

  logic [NUM_REQ-1:0]               arb_gnt_s;
  logic [IDX_W-1:0]                 arb_idx_s;
  logic                             arb_vld_s;
  logic [IDX_W-1:0]                 rr_ptr_d;
  logic [CSB_REQ_PD_W-1:0]          sel_pd_s;
  logic                             rsp_fire_s;
  logic [CSB_RESP_PD_W-1:0]         rsp_data_s;
  logic [NUM_REQ-1:0]               resp_valid_d;
  logic [CSB_RESP_PD_W*NUM_REQ-1:0] resp_pd_d;
  logic                             posted_s;

  nvdla_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req_i     (req_pvld),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt_s),
    .gnt_idx_o (arb_idx_s),
    .gnt_vld_o (arb_vld_s)
  );

  // Ready goes straight back to the winner while idle; held low under reset.
  always_comb begin
    if (!nvdla_core_rst && (state_q == ST_IDLE)) begin
      req_prdy = arb_gnt_s;
    end else begin
      req_prdy = '0;
    end
  end

  // Payload of the current winner and the pointer to search from next time.
  always_comb begin
    sel_pd_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_pd_s = sel_pd_s | (req_pd[i*CSB_REQ_PD_W +: CSB_REQ_PD_W] & {CSB_REQ_PD_W{arb_gnt_s[i]}});
    end
    if (arb_idx_s == IDX_LAST) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = arb_idx_s + IDX_W'(1);
    end
  end

  // Decide whether a response is returned this cycle; a real one beats timeout.
  always_comb begin
    posted_s   = pd_q[CSB_REQ_WRITE_BIT] & ~pd_q[CSB_REQ_NPOSTED_BIT];
    rsp_fire_s = 1'b0;
    rsp_data_s = '0;
    if (state_q == ST_WAIT_RESP) begin
      if (cfgrom2csb_resp_valid) begin
        rsp_fire_s = 1'b1;
        rsp_data_s = cfgrom2csb_resp_pd;
      end else if (cnt_q == CNT_LAST) begin
        rsp_fire_s = 1'b1;
        rsp_data_s = csb_err_resp(pd_q[CSB_REQ_WRITE_BIT]);
      end else begin
        rsp_fire_s = 1'b0;
        rsp_data_s = '0;
      end
    end else begin
      rsp_fire_s = 1'b0;
      rsp_data_s = '0;
    end
  end

  // Steer the response into the granted master's slice; all others stay zero.
  always_comb begin
    resp_pd_d = '0;
    if (rsp_fire_s) begin
      resp_valid_d = gnt_oh_q;
    end else begin
      resp_valid_d = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_pd_d[i*CSB_RESP_PD_W +: CSB_RESP_PD_W] = rsp_data_s & {CSB_RESP_PD_W{resp_valid_d[i]}};
    end
  end

  // Arbitration FSM with its registered cfgrom-side and response-side outputs.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gnt_oh_q     <= '0;
      pd_q         <= '0;
      pvld_q       <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_pd_q    <= '0;
      resp_drop_q  <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_pd_q    <= resp_pd_d;
      resp_drop_q  <= cfgrom2csb_resp_valid && (state_q != ST_WAIT_RESP);
      case (state_q)
        ST_IDLE: begin
          if (arb_vld_s) begin
            pd_q     <= sel_pd_s;
            gnt_oh_q <= arb_gnt_s;
            rr_ptr_q <= rr_ptr_d;
            pvld_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (csb2cfgrom_req_prdy) begin
            pvld_q <= 1'b0;
            cnt_q  <= '0;
            if (posted_s) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_RESP;
            end
          end
        end
        ST_WAIT_RESP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (rsp_fire_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          pvld_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign csb2cfgrom_req_pd   = pd_q;
  assign csb2cfgrom_req_pvld = pvld_q;
  assign resp_valid          = resp_valid_q;
  assign resp_pd             = resp_pd_q;
  assign resp_drop           = resp_drop_q;

endmodule

// File: tb/tb_nvdla_cfgrom_csb_arb.sv
// Directed self-checking bench for nvdla_cfgrom_csb_arb (NUM_REQ=4, TIMEOUT=8).
module tb_nvdla_cfgrom_csb_arb;
  import nvdla_csb_pkg::*;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  typedef logic [135:0] v_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [63*NREQ-1:0] req_pd;
  logic [NREQ-1:0]   req_pvld;
  logic [NREQ-1:0]   req_prdy;
  logic [34*NREQ-1:0] resp_pd;
  logic [NREQ-1:0]   resp_valid;
  logic [62:0]       c_req_pd;
  logic              c_req_pvld;
  logic              c_req_prdy;
  logic [33:0]       c_resp_pd;
  logic              c_resp_valid;
  logic              resp_drop;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nvdla_cfgrom_csb_arb #(.NUM_REQ(NREQ), .TIMEOUT(TO)) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .req_pd                (req_pd),
    .req_pvld              (req_pvld),
    .req_prdy              (req_prdy),
    .resp_pd               (resp_pd),
    .resp_valid            (resp_valid),
    .csb2cfgrom_req_pd     (c_req_pd),
    .csb2cfgrom_req_pvld   (c_req_pvld),
    .csb2cfgrom_req_prdy   (c_req_prdy),
    .cfgrom2csb_resp_pd    (c_resp_pd),
    .cfgrom2csb_resp_valid (c_resp_valid),
    .resp_drop             (resp_drop)
  );

  task automatic chk_eq(input string tag, input v_t got, input v_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [62:0] mk_req(input logic [21:0] addr, input logic [31:0] wdat,
                                         input logic wr, input logic np);
    logic [62:0] p;
    p = '0;
    p[21:0]  = addr;
    p[53:22] = wdat;
    p[54]    = wr;
    p[55]    = np;
    return p;
  endfunction

  function automatic v_t rsp_at(input int idx, input logic [33:0] pd);
    v_t r;
    r = '0;
    r[34*idx +: 34] = pd;
    return r;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [62:0] pd);
    req_pd[63*i +: 63] = pd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_req_prdy"}, v_t'(req_prdy), v_t'(0));
    chk_eq({tag, "_cfg_pvld"}, v_t'(c_req_pvld), v_t'(0));
    chk_eq({tag, "_cfg_pd"}, v_t'(c_req_pd), v_t'(0));
    chk_eq({tag, "_resp_valid"}, v_t'(resp_valid), v_t'(0));
    chk_eq({tag, "_resp_pd"}, v_t'(resp_pd), v_t'(0));
    chk_eq({tag, "_resp_drop"}, v_t'(resp_drop), v_t'(0));
  endtask

  logic [62:0] pd_a;
  logic [62:0] pd_b;
  logic [3:0]  e_oh;
  logic [33:0] e_pd;

  initial begin
    req_pd = '0; req_pvld = '0; c_req_prdy = 1'b0; c_resp_pd = '0; c_resp_valid = 1'b0;

    // Reset state, with all masters requesting
    #3;
    req_pvld = 4'hF;
    #1;
    chk_all_zero("reset");
    req_pvld = 4'h0;
    nxt(); rst = 1'b0;
    nxt();

    // Test 1: single read from master 2
    set_req(2, mk_req(22'h10, 32'h0, 1'b0, 1'b0)); req_pvld = 4'b0100; #1;
    chk_eq("t1_prdy", v_t'(req_prdy), v_t'(4'b0100));
    nxt(); req_pvld = 4'b0000; c_req_prdy = 1'b1; #1;
    chk_eq("t1_issue_pvld", v_t'(c_req_pvld), v_t'(1'b1));
    chk_eq("t1_issue_pd", v_t'(c_req_pd), v_t'(63'h10));
    chk_eq("t1_issue_prdy", v_t'(req_prdy), v_t'(0));
    nxt(); c_req_prdy = 1'b0; #1;
    chk_eq("t1_wait_pvld", v_t'(c_req_pvld), v_t'(0));
    nxt();
    nxt(); c_resp_valid = 1'b1; c_resp_pd = 34'h0_1234_5678; #1;
    chk_eq("t1_no_early", v_t'(resp_valid), v_t'(0));
    nxt(); c_resp_valid = 1'b0; c_resp_pd = '0; #1;
    chk_eq("t1_resp_valid", v_t'(resp_valid), v_t'(4'b0100));
    chk_eq("t1_resp_pd", v_t'(resp_pd), rsp_at(2, 34'h0_1234_5678));
    chk_eq("t1_no_drop", v_t'(resp_drop), v_t'(0));
    nxt(); #1;
    chk_eq("t1_once", v_t'(resp_valid), v_t'(0));

    // Test 2: fairness with all masters requesting, pointer back at 0
    rst = 1'b1; #1; rst = 1'b0;
    nxt();
    for (int i = 0; i < NREQ; i++) set_req(i, mk_req(22'h100 + 22'(i), 32'h0, 1'b0, 1'b0));
    req_pvld = 4'hF; c_req_prdy = 1'b1;
    for (int t = 0; t < 6; t++) begin
      c_resp_valid = 1'b0; #1;
      e_oh = 4'b0001 << (t % 4);
      chk_eq("t2_grant", v_t'(req_prdy), v_t'(e_oh));
      if (t > 0) begin
        e_oh = 4'b0001 << ((t - 1) % 4);
        e_pd = 34'h100 + 34'(t - 1);
        chk_eq("t2_prev_resp", v_t'(resp_valid), v_t'(e_oh));
        chk_eq("t2_prev_pd", v_t'(resp_pd), rsp_at((t - 1) % 4, e_pd));
      end else begin
        chk_eq("t2_first_resp", v_t'(resp_valid), v_t'(0));
      end
      nxt(); #1;
      chk_eq("t2_issue_pd", v_t'(c_req_pd), v_t'(mk_req(22'h100 + 22'(t % 4), 32'h0, 1'b0, 1'b0)));
      chk_eq("t2_issue_noprdy", v_t'(req_prdy), v_t'(0));
      nxt();
      c_resp_valid = 1'b1; c_resp_pd = 34'h100 + 34'(t);
      nxt();
    end
    c_resp_valid = 1'b0; req_pvld = 4'h0; c_req_prdy = 1'b0; #1;
    chk_eq("t2_last_resp", v_t'(resp_valid), v_t'(4'b0010));
    chk_eq("t2_last_pd", v_t'(resp_pd), rsp_at(1, 34'h105));
    nxt();

    // Test 3: posted write from master 1, then nonposted write from master 0
    pd_a = mk_req(22'h20, 32'h0000_CAFE, 1'b1, 1'b0);
    set_req(1, pd_a); req_pvld = 4'b0010; #1;
    chk_eq("t3_prdy", v_t'(req_prdy), v_t'(4'b0010));
    nxt(); req_pvld = 4'b0000; c_req_prdy = 1'b1; #1;
    chk_eq("t3_issue_pd", v_t'(c_req_pd), v_t'(pd_a));
    nxt(); c_req_prdy = 1'b0;
    set_req(0, mk_req(22'h30, 32'h0000_5A5A, 1'b1, 1'b1)); req_pvld = 4'b0001; #1;
    chk_eq("t3_back_idle", v_t'(req_prdy), v_t'(4'b0001));
    chk_eq("t3_pvld_low", v_t'(c_req_pvld), v_t'(0));
    chk_eq("t3_posted_noresp", v_t'(resp_valid), v_t'(0));
    nxt(); req_pvld = 4'b0000; c_req_prdy = 1'b1; #1;
    chk_eq("t3_np_issue", v_t'(c_req_pvld), v_t'(1'b1));
    chk_eq("t3_posted_noresp2", v_t'(resp_valid), v_t'(0));
    nxt(); c_req_prdy = 1'b0; c_resp_valid = 1'b1; c_resp_pd = 34'h2_0000_0000; #1;
    chk_eq("t3_posted_noresp3", v_t'(resp_valid), v_t'(0));
    nxt(); c_resp_valid = 1'b0; c_resp_pd = '0; #1;
    chk_eq("t3_np_resp", v_t'(resp_valid), v_t'(4'b0001));
    chk_eq("t3_np_pd", v_t'(resp_pd), rsp_at(0, 34'h2_0000_0000));
    nxt();

    // Test 4: timeout on a read from master 3, then a late response
    set_req(3, mk_req(22'h40, 32'h0, 1'b0, 1'b0)); req_pvld = 4'b1000; #1;
    chk_eq("t4_prdy", v_t'(req_prdy), v_t'(4'b1000));
    nxt(); req_pvld = 4'b0000; c_req_prdy = 1'b1;
    nxt(); c_req_prdy = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk_eq("t4_silent", v_t'(resp_valid), v_t'(0));
      nxt();
    end
    #1;
    chk_eq("t4_to_valid", v_t'(resp_valid), v_t'(4'b1000));
    chk_eq("t4_to_pd", v_t'(resp_pd), rsp_at(3, 34'h1_0000_0000));
    chk_eq("t4_to_nodrop", v_t'(resp_drop), v_t'(0));
    nxt(); #1;
    chk_eq("t4_to_once", v_t'(resp_valid), v_t'(0));
    nxt();
    nxt(); c_resp_valid = 1'b1; c_resp_pd = 34'h0_0000_DEAD;
    nxt(); c_resp_valid = 1'b0; c_resp_pd = '0; #1;
    chk_eq("t4_late_drop", v_t'(resp_drop), v_t'(1'b1));
    chk_eq("t4_late_novalid", v_t'(resp_valid), v_t'(0));
    nxt(); #1;
    chk_eq("t4_drop_pulse", v_t'(resp_drop), v_t'(0));

    // Real response in the last waiting cycle beats the timeout
    set_req(0, mk_req(22'h44, 32'h0, 1'b0, 1'b0)); req_pvld = 4'b0001; #1;
    chk_eq("t4b_prdy", v_t'(req_prdy), v_t'(4'b0001));
    nxt(); req_pvld = 4'b0000; c_req_prdy = 1'b1;
    nxt(); c_req_prdy = 1'b0;
    repeat (7) nxt();
    c_resp_valid = 1'b1; c_resp_pd = 34'h0_0000_BEEF;
    nxt(); c_resp_valid = 1'b0; c_resp_pd = '0; #1;
    chk_eq("t4b_real_valid", v_t'(resp_valid), v_t'(4'b0001));
    chk_eq("t4b_real_pd", v_t'(resp_pd), rsp_at(0, 34'h0_0000_BEEF));
    chk_eq("t4b_nodrop", v_t'(resp_drop), v_t'(0));
    nxt(); #1;
    chk_eq("t4b_no_second", v_t'(resp_valid), v_t'(0));

    // Test 5: cfgrom backpressure on a read from master 2
    pd_b = mk_req(22'h55, 32'h1111_2222, 1'b0, 1'b0);
    set_req(2, pd_b); req_pvld = 4'b0100; #1;
    chk_eq("t5_prdy", v_t'(req_prdy), v_t'(4'b0100));
    nxt(); req_pvld = 4'b1011; set_req(2, 63'h0); c_req_prdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_eq("t5_bp_pvld", v_t'(c_req_pvld), v_t'(1'b1));
      chk_eq("t5_bp_pd", v_t'(c_req_pd), v_t'(pd_b));
      chk_eq("t5_bp_noprdy", v_t'(req_prdy), v_t'(0));
      nxt();
    end
    c_req_prdy = 1'b1; req_pvld = 4'b0000; #1;
    chk_eq("t5_accept_pvld", v_t'(c_req_pvld), v_t'(1'b1));
    nxt(); c_req_prdy = 1'b0; #1;
    chk_eq("t5_wait_pvld", v_t'(c_req_pvld), v_t'(0));
    chk_eq("t5_wait_pd_held", v_t'(c_req_pd), v_t'(pd_b));

    // Test 6: reset while waiting for the response
    req_pvld = 4'hF; rst = 1'b1; #1;
    chk_all_zero("t6_rst");
    req_pvld = 4'h0;
    nxt(); rst = 1'b0;
    c_resp_valid = 1'b1; c_resp_pd = 34'h0_0000_0077;
    nxt(); c_resp_valid = 1'b0; c_resp_pd = '0; #1;
    chk_eq("t6_drop", v_t'(resp_drop), v_t'(1'b1));
    chk_eq("t6_novalid", v_t'(resp_valid), v_t'(0));
    req_pvld = 4'hF; #1;
    chk_eq("t6_rrptr0", v_t'(req_prdy), v_t'(4'b0001));
    nxt(); req_pvld = 4'h0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
